// File: rtl/fpcvt_pkg.sv
// Shared defaults, exponent limit helper and the per-stage control payload
// for the pipelined fixed-to-float converter.
package fpcvt_pkg;

   localparam int DW_DEF = 12;   // input word width
   localparam int EW_DEF = 3;    // exponent width
   localparam int FW_DEF = 4;    // fraction width, leading one explicit
   localparam int CW_DEF = 8;    // saturation counter width

   // Largest representable exponent for an ew-bit exponent field
   function automatic int emax(input int ew);
      return (1 << ew) - 1;
   endfunction

   // Control bits that travel with every sample through the stages;
   // the width-dependent payload (magnitude, bit position) is added by
   // the pipeline, where DW is known.
   typedef struct packed {
      logic valid;
      logic sign;
      logic rnd;
   } fpcvt_ctl_t;

endpackage

// File: rtl/fpcvt_lod.sv
// Combinational leading-one detector: index of the highest set bit of vec,
// with a zero flag when no bit is set (pos is then 0 and meaningless).
module fpcvt_lod #(
   parameter int DW = 12
) (
   input  logic [DW-1:0]         vec,
   output logic [$clog2(DW)-1:0] pos,
   output logic                  zero
);

   localparam int PW = $clog2(DW);

   // Scan upward so the highest set bit is the last one to win
   always_comb begin
      pos  = '0;
      zero = 1'b1;
      for (int unsigned i = 0; i < DW; i++) begin
         if (vec[i]) begin
            pos  = PW'(i);
            zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage pipelined fixed-to-float converter with valid/ready handshake,
// per-sample rounding mode, saturation flag and a sticky saturation counter.
// Stage 1: sign/magnitude, stage 2: leading-one detect, stage 3: normalise,
// round and saturate into the output registers.
module fpcvt_pipe
   import fpcvt_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int EW = EW_DEF,
   parameter int FW = FW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_cnt,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_rnd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_s,
   output logic [EW-1:0] out_e,
   output logic [FW-1:0] out_f,
   output logic          out_sat,
   output logic [CW-1:0] sat_cnt
);

   localparam int PW   = $clog2(DW);
   localparam int EMAX = emax(EW);

   typedef struct packed {
      fpcvt_ctl_t    ctl;
      logic [DW-1:0] mag;
   } s1_t;

   typedef struct packed {
      fpcvt_ctl_t    ctl;
      logic [DW-1:0] mag;
      logic [PW-1:0] p;
      logic          zero;
   } s2_t;

   s1_t s1;
   s2_t s2;

   logic          ready1, ready2, ready3;
   logic [DW-1:0] in_mag;
   logic [PW-1:0] lod_p;
   logic          lod_zero;

   logic          n_s, n_sat;
   logic [EW-1:0] n_e;
   logic [FW-1:0] n_f;
   logic [PW-1:0] sh, rb_idx;
   logic [FW-1:0] f0;
   logic          rbit;
   logic [FW:0]   f_rnd;
   logic [PW:0]   e_fin;

   // A stage may load when it is empty or its successor will take its content
   assign ready3   = !out_valid | out_ready;
   assign ready2   = !s2.ctl.valid | ready3;
   assign ready1   = !s1.ctl.valid | ready2;
   assign in_ready = ready1;

   // DW-bit negate: the most negative input yields 2^(DW-1) as unsigned
   assign in_mag = in_data[DW-1] ? (~in_data + DW'(1)) : in_data;

   fpcvt_lod #(.DW(DW)) u_lod (
      .vec  (s1.mag),
      .pos  (lod_p),
      .zero (lod_zero)
   );

   // Stage 1 register: sign, magnitude and rounding mode of the accepted sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
      end else if (ready1) begin
         s1.ctl.valid <= in_valid;
         s1.ctl.sign  <= in_data[DW-1];
         s1.ctl.rnd   <= in_rnd;
         s1.mag       <= in_mag;
      end
   end

   // Stage 2 register: adds leading-one position and zero tag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2 <= '0;
      end else if (ready2) begin
         s2 <= {s1.ctl, s1.mag, lod_p, lod_zero};
      end
   end

   // Normalise, round and saturate the stage-2 sample
   always_comb begin
      n_s    = s2.ctl.sign & ~s2.zero;
      n_e    = '0;
      n_f    = '0;
      n_sat  = 1'b0;
      sh     = s2.p - PW'(FW - 1);
      rb_idx = s2.p - PW'(FW);
      f0     = FW'(s2.mag >> sh);
      rbit   = s2.mag[rb_idx];
      f_rnd  = {1'b0, f0} + (FW + 1)'(s2.ctl.rnd & rbit);
      e_fin  = {1'b0, sh} + (PW + 1)'(f_rnd[FW]);
      if (s2.zero) begin
         n_s = 1'b0;
      end else if (int'(s2.p) < FW) begin
         n_f = s2.mag[FW-1:0];
      end else if (int'(e_fin) > EMAX) begin
         n_e   = '1;
         n_f   = '1;
         n_sat = 1'b1;
      end else begin
         n_e = EW'(e_fin);
         // On carry-out f_rnd is 1 followed by FW zeros, so its top FW bits
         // are already the renormalised fraction.
         n_f = f_rnd[FW] ? f_rnd[FW:1] : f_rnd[FW-1:0];
      end
   end

   // Output register stage; holds its word while downstream stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_s     <= 1'b0;
         out_e     <= '0;
         out_f     <= '0;
         out_sat   <= 1'b0;
      end else if (ready3) begin
         out_valid <= s2.ctl.valid;
         if (s2.ctl.valid) begin
            out_s   <= n_s;
            out_e   <= n_e;
            out_f   <= n_f;
            out_sat <= n_sat;
         end
      end
   end

   // Count delivered saturated results, sticking at all-ones; clear wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt <= '0;
      end else if (clr_cnt) begin
         sat_cnt <= '0;
      end else if (out_valid && out_ready && out_sat && (sat_cnt != '1)) begin
         sat_cnt <= sat_cnt + CW'(1);
      end
   end

endmodule
